ofmap_collector: RTL and testbench
==================================

Name: ofmap_collector

Overview:
- Downstream stage of the systolic datapath. Consumes the column-skewed partial sums from the array (`of_data`, one lane per array column) and deskews them into a row-ordered accumulator.
- Accumulates across K-tiles. After the last tile it post-processes each value (optional ReLU, arithmetic shift, signed saturation) and streams one output row per valid/ready handshake to the output feature-map writer.

Parameters:
- SYS_COLS, 4, number of array columns / output lanes (matches sys_cols)
- ROWS, 4, output rows per tile (matches A_rows)
- P_BW, 32, partial-sum width per lane (matches P_BITWIDTH)
- OUT_BW, 8, quantized output width per lane
- SHIFT_W, 5, width of the shift-amount input

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a tile; latches first/last/shift/relu_en
- first  in  1  1 = overwrite accumulator this tile, 0 = add to it
- last  in  1  1 = drain after this tile completes
- shift  in  SHIFT_W  right-shift amount for quantization
- relu_en  in  1  clamp negatives to 0 before shifting
- col_valid  in  SYS_COLS  per-lane valid for of_data
- of_data  in  SYS_COLS*P_BW  signed partial sums, lane c at bits [c*P_BW +: P_BW]
- o_valid  out  1  output row valid
- o_ready  in  1  downstream ready
- o_data  out  SYS_COLS*OUT_BW  quantized row, lane c at bits [c*OUT_BW +: OUT_BW]
- busy  out  1  state != IDLE
- tile_done  out  1  one-cycle pulse when a non-last tile completes
- done  out  1  one-cycle pulse on final drain handshake
- err  out  1  sticky protocol-error flag, cleared by start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, per-lane row counters=0, lane-done bits=0, drain pointer=0. o_valid, busy, tile_done, done and err all 0. Accumulator RAM is not reset; the first tile after reset must use first=1.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - start → COLLECT; clears row counters, lane-done bits and err; latches the control inputs.
- COLLECT:
  - Each lane is handled independently. col_valid[c] with lane c not done writes acc[row_cnt[c]][c].
  - Write value: of_data lane c if first=1, else acc + of_data, modulo 2^P_BW. Then row_cnt[c] increments.
  - The write at row_cnt[c]=ROWS-1 sets done[c].
  - Arbitrary skew between lanes is tolerated, including all lanes valid in the same cycle.
  - The cycle after all done bits are set:
    - last=1 → DRAIN.
    - last=0 → IDLE with tile_done=1 for one cycle.
  - start during COLLECT aborts and restarts the tile: counters cleared, new controls latched, no error.
- DRAIN:
  - o_valid=1. o_data = quantize(acc[ptr]); ptr is registered.
  - o_data holds stable while o_valid & !o_ready.
  - On o_valid & o_ready: ptr increments. On the handshake at ptr=ROWS-1: → IDLE, ptr=0, done=1 for one cycle, o_valid=0 next cycle.
  - First o_valid appears one cycle after the final lane write.
- Quantize, per lane:
  - v = (relu_en && v<0) ? 0 : v.
  - v = v >>> shift (arithmetic).
  - Saturate to [-2^(OUT_BW-1), 2^(OUT_BW-1)-1].
- Errors, each sets err and causes no state or RAM change:
  - col_valid[c] while lane c done, or in IDLE or DRAIN.
  - start in DRAIN (ignored).
- Reset mid-operation: immediate return to the reset state; any partial drain is discarded.

Test Plan:
- Single tile, first=last=1, shift=2, relu_en=1, lane c row r value 16(r+1)+c injected at cycle r+c → rows 0..3 out as (16(r+1)+c)>>2, e.g. row0 = {4,4,4,4}, row3 = {16,16,16,16}; done pulses once.
- Two tiles, each lane value 100 (first=1, last=0), then 50 (first=0, last=1), shift=0:
  - tile_done after tile 1.
  - Outputs are 127 (150 saturated) on all lanes.
- Negatives, shift=1:
  - -40 with relu_en=0 → -20; with relu_en=1 → 0.
  - -1000 with relu_en=0 → -128.
- Backpressure, o_ready toggling 1/0 each cycle: exactly 4 handshakes, o_data stable during stalls, done on the 4th handshake, busy=0 the next cycle.
- Errors:
  - Fifth col_valid on lane 2 → err=1, lane-2 outputs unchanged.
  - start during DRAIN → err=1, drain continues unaffected.
  - Next start in IDLE → err=0.
- Reset asserted after 2 drained rows → o_valid=0 and busy=0 immediately.
  - A new first=last=1 tile then produces a correct full 4-row output.

Source files
------------

// File: rtl/ofmap_collector.sv
// Deskews column-skewed partial sums into a row-ordered accumulator across K-tiles,
// then quantizes (ReLU, arithmetic shift, saturation) and streams one row per handshake.
module ofmap_collector #(
   parameter int SYS_COLS = 4,
   parameter int ROWS     = 4,
   parameter int P_BW     = 32,
   parameter int OUT_BW   = 8,
   parameter int SHIFT_W  = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       first,
   input  logic                       last,
   input  logic [SHIFT_W-1:0]         shift,
   input  logic                       relu_en,
   input  logic [SYS_COLS-1:0]        col_valid,
   input  logic [SYS_COLS*P_BW-1:0]   of_data,
   output logic                       o_valid,
   input  logic                       o_ready,
   output logic [SYS_COLS*OUT_BW-1:0] o_data,
   output logic                       busy,
   output logic                       tile_done,
   output logic                       done,
   output logic                       err
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
   localparam logic signed [P_BW-1:0] Q_MAX = {{(P_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
   localparam logic signed [P_BW-1:0] Q_MIN = {{(P_BW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        row_cnt_q [SYS_COLS];
   logic [CNT_W-1:0]        row_cnt_d [SYS_COLS];
   logic [SYS_COLS-1:0]     lane_done_q, lane_done_d;
   logic [CNT_W-1:0]        ptr_q, ptr_d;
   logic                    first_q, first_d;
   logic                    last_q, last_d;
   logic                    relu_q, relu_d;
   logic [SHIFT_W-1:0]      shift_q, shift_d;
   logic                    err_q, err_d;
   logic                    tile_done_q, tile_done_d;

   logic signed [P_BW-1:0]  acc_q   [ROWS][SYS_COLS];
   logic signed [P_BW-1:0]  lane_in [SYS_COLS];
   logic signed [P_BW-1:0]  wr_data [SYS_COLS];
   logic [SYS_COLS-1:0]     wr_en;

   function automatic logic [OUT_BW-1:0] quantize(input logic signed [P_BW-1:0] v,
                                                  input logic [SHIFT_W-1:0]    sh,
                                                  input logic                  relu);
      logic signed [P_BW-1:0] r;
      logic signed [P_BW-1:0] s;
      r = (relu && (v < 0)) ? '0 : v;
      s = r >>> sh;
      if (s > Q_MAX)      return Q_MAX[OUT_BW-1:0];
      else if (s < Q_MIN) return Q_MIN[OUT_BW-1:0];
      else                return s[OUT_BW-1:0];
   endfunction

   // A lane write is suppressed by a restarting start or by the lane already being full
   always_comb begin
      for (int c = 0; c < SYS_COLS; c++) begin
         lane_in[c] = of_data[c*P_BW +: P_BW];
         wr_en[c]   = (state_q == COLLECT) && !start && col_valid[c] && !lane_done_q[c];
         wr_data[c] = first_q ? lane_in[c] : acc_q[row_cnt_q[c]][c] + lane_in[c];
      end
   end

   always_comb begin
      row_cnt_d   = row_cnt_q;
      lane_done_d = lane_done_q;
      ptr_d       = ptr_q;
      first_d     = first_q;
      last_d      = last_q;
      relu_d      = relu_q;
      shift_d     = shift_q;
      err_d       = err_q;
      case (state_q)
         IDLE, COLLECT: begin
            if (start) begin
               for (int c = 0; c < SYS_COLS; c++) row_cnt_d[c] = '0;
               lane_done_d = '0;
               ptr_d       = '0;
               err_d       = 1'b0;
               first_d     = first;
               last_d      = last;
               relu_d      = relu_en;
               shift_d     = shift;
            end else if (state_q == IDLE) begin
               if (|col_valid) err_d = 1'b1;
            end else begin
               for (int c = 0; c < SYS_COLS; c++) begin
                  if (col_valid[c]) begin
                     if (lane_done_q[c]) begin
                        err_d = 1'b1;
                     end else begin
                        row_cnt_d[c] = row_cnt_q[c] + CNT_W'(1);
                        if (row_cnt_q[c] == LAST_ROW) lane_done_d[c] = 1'b1;
                     end
                  end
               end
            end
         end
         DRAIN: begin
            if (start || (|col_valid)) err_d = 1'b1;
            if (o_ready) ptr_d = (ptr_q == LAST_ROW) ? '0 : ptr_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COLLECT;
         COLLECT: if (!start && (&lane_done_d)) state_d = last_q ? DRAIN : IDLE;
         DRAIN:   if (o_ready && (ptr_q == LAST_ROW)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign tile_done_d = (state_q == COLLECT) && !start && (&lane_done_d) && !last_q;

   always_comb begin
      o_valid   = (state_q == DRAIN);
      busy      = (state_q != IDLE);
      done      = (state_q == DRAIN) && o_ready && (ptr_q == LAST_ROW);
      tile_done = tile_done_q;
      err       = err_q;
      o_data    = '0;
      for (int c = 0; c < SYS_COLS; c++)
         o_data[c*OUT_BW +: OUT_BW] = quantize(acc_q[ptr_q][c], shift_q, relu_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         for (int c = 0; c < SYS_COLS; c++) row_cnt_q[c] <= '0;
         lane_done_q <= '0;
         ptr_q       <= '0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         relu_q      <= 1'b0;
         shift_q     <= '0;
         err_q       <= 1'b0;
         tile_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         lane_done_q <= lane_done_d;
         ptr_q       <= ptr_d;
         first_q     <= first_d;
         last_q      <= last_d;
         relu_q      <= relu_d;
         shift_q     <= shift_d;
         err_q       <= err_d;
         tile_done_q <= tile_done_d;
      end
   end

   // Accumulator storage is deliberately left unreset; a first=1 tile initialises it
   always_ff @(posedge clk) begin
      for (int c = 0; c < SYS_COLS; c++)
         if (wr_en[c]) acc_q[row_cnt_q[c]][c] <= wr_data[c];
   end

endmodule

// File: tb/tb_ofmap_collector.sv
// Randomized bench for ofmap_collector with a row/lane accumulator reference model.
module tb_ofmap_collector;

   localparam int COLS = 4;
   localparam int ROWS = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             first;
   logic             last;
   logic [4:0]       shift;
   logic             relu_en;
   logic [COLS-1:0]  col_valid;
   logic [COLS*32-1:0] of_data;
   logic             o_valid;
   logic             o_ready;
   logic [COLS*8-1:0] o_data;
   logic             busy;
   logic             tile_done;
   logic             done;
   logic             err;

   int tests = 0;
   int fails = 0;
   int acc_m [ROWS][COLS];
   int vals  [ROWS][COLS];
   int sh_m;
   bit relu_m;
   logic [31:0] cap [ROWS];
   bit inject = 0;

   ofmap_collector dut (
      .clk(clk), .rst(rst), .start(start), .first(first), .last(last),
      .shift(shift), .relu_en(relu_en), .col_valid(col_valid), .of_data(of_data),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .busy(busy),
      .tile_done(tile_done), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] q_m(input int v, input int sh, input bit relu);
      longint x;
      logic [63:0] b;
      x = v;
      if (relu && x < 0) x = 0;
      x = x >>> sh;
      if (x > 127) x = 127;
      if (x < -128) x = -128;
      b = x;
      return b[7:0];
   endfunction

   function automatic logic [31:0] exp_row(input int r);
      logic [31:0] e;
      for (int c = 0; c < COLS; c++) e[c*8 +: 8] = q_m(acc_m[r][c], sh_m, relu_m);
      return e;
   endfunction

   task automatic run_tile(input bit f, input bit l, input int sh, input bit relu, input int mode);
      int idx [COLS];
      int t;
      int r;
      bit fin;
      @(negedge clk);
      start = 1; first = f; last = l; shift = 5'(sh); relu_en = relu; col_valid = '0;
      sh_m = sh; relu_m = relu;
      for (int c = 0; c < COLS; c++) idx[c] = 0;
      t = 0; fin = 0;
      while (!fin && t < 100) begin
         @(negedge clk);
         start = 0; col_valid = '0; of_data = '0;
         for (int c = 0; c < COLS; c++) begin
            r = -1;
            if (mode == 0) begin
               if (t >= c && t - c < ROWS) r = t - c;
            end else if (idx[c] < ROWS && $urandom_range(0, 1) == 1) r = idx[c];
            if (r >= 0) begin
               col_valid[c] = 1'b1;
               of_data[c*32 +: 32] = vals[r][c];
               acc_m[r][c] = f ? vals[r][c] : acc_m[r][c] + vals[r][c];
               idx[c]++;
            end
         end
         if (inject && mode == 0 && t == ROWS + COLS - 2) begin
            col_valid[2] = 1'b1;
            of_data[2*32 +: 32] = 12345;
         end
         #1;
         if (t == 0) begin
            tests++;
            if (err !== 1'b0 || busy !== 1'b1) begin
               fails++;
               $display("FAIL start_state: err=%b busy=%b, required err=0 busy=1", err, busy);
            end
         end
         t++;
         fin = 1;
         for (int c = 0; c < COLS; c++) if (idx[c] < ROWS) fin = 0;
      end
      tests++;
      if (!fin) begin
         fails++;
         $display("FAIL feed_timeout: lanes not filled in %0d cycles", t);
      end
      @(negedge clk);
      col_valid = '0; of_data = '0;
      #1;
      tests++;
      if (l) begin
         if (o_valid !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL first_valid: o_valid=%b done=%b, required 1 0", o_valid, done);
         end
      end else begin
         if (tile_done !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL tile_done: tile_done=%b busy=%b o_valid=%b, required 1 0 0",
                     tile_done, busy, o_valid);
         end
      end
   endtask

   // ready_mode: 0 always ready, 1 toggling, 2 random; start_at pulses start in that cycle
   task automatic drain(input int ready_mode, input int start_at, input int n_rows);
      int hs = 0;
      int cyc = 0;
      int dones = 0;
      bit stalled = 0;
      logic [31:0] held = '0;
      while (hs < n_rows && cyc < 200) begin
         @(negedge clk);
         cyc++;
         case (ready_mode)
            0: o_ready = 1'b1;
            1: o_ready = (cyc % 2) == 1;
            default: o_ready = ($urandom_range(0, 1) == 1);
         endcase
         start = (cyc == start_at);
         if (cyc == start_at) shift = ~shift;
         #1;
         tests++;
         if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL drain_valid: o_valid=%b at row %0d, required 1", o_valid, hs);
         end
         if (start_at > 0 && cyc == start_at + 1) begin
            tests++;
            if (err !== 1'b1) begin
               fails++;
               $display("FAIL start_in_drain_err: err=%b, required 1", err);
            end
         end
         if (stalled) begin
            tests++;
            if (o_data !== held) begin
               fails++;
               $display("FAIL stall_hold: o_data=%h, required %h", o_data, held);
            end
         end
         if (o_valid && o_ready) begin
            tests++;
            if (o_data !== exp_row(hs)) begin
               fails++;
               $display("FAIL row_data: row %0d o_data=%h, required %h", hs, o_data, exp_row(hs));
            end
            tests++;
            if (done !== (hs == ROWS - 1)) begin
               fails++;
               $display("FAIL done_pulse: row %0d done=%b, required %b", hs, done, hs == ROWS - 1);
            end
            if (done) dones++;
            cap[hs] = o_data;
            hs++;
            stalled = 0;
         end else begin
            tests++;
            if (done !== 1'b0) begin
               fails++;
               $display("FAIL done_stall: done=%b, required 0", done);
            end
            stalled = o_valid;
            held = o_data;
         end
      end
      tests++;
      if (hs < n_rows) begin
         fails++;
         $display("FAIL drain_timeout: %0d handshakes, required %0d", hs, n_rows);
      end
      start = 0;
      if (n_rows == ROWS) begin
         @(negedge clk);
         o_ready = 0;
         #1;
         tests++;
         if (o_valid !== 1'b0 || busy !== 1'b0 || dones != 1) begin
            fails++;
            $display("FAIL drain_end: o_valid=%b busy=%b dones=%0d, required 0 0 1", o_valid, busy, dones);
         end
      end
   endtask

   task automatic fill_const(input int v);
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) vals[r][c] = v;
   endtask

   task automatic fill_rand(input int lo, input int hi);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) vals[r][c] = lo + int'($urandom_range(0, hi - lo));
   endtask

   task automatic test_reset();
      rst = 0; start = 0; first = 0; last = 0; shift = 0; relu_en = 0;
      col_valid = '0; of_data = '0; o_ready = 0;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if ({o_valid, busy, tile_done, done, err} !== 5'b0) begin
         fails++;
         $display("FAIL reset_outputs: {o_valid,busy,tile_done,done,err}=%b, required 00000",
                  {o_valid, busy, tile_done, done, err});
      end
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_single_tile();
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) vals[r][c] = 16 * (r + 1) + c;
      run_tile(1, 1, 2, 1, 0);
      drain(0, -1, ROWS);
      tests++;
      if (cap[0] !== 32'h04040404 || cap[3] !== 32'h10101010) begin
         fails++;
         $display("FAIL single_tile_const: row0=%h row3=%h, required 04040404 10101010", cap[0], cap[3]);
      end
   endtask

   task automatic test_two_tiles();
      fill_const(100);
      run_tile(1, 0, 0, 0, 1);
      fill_const(50);
      run_tile(0, 1, 0, 0, 1);
      drain(2, -1, ROWS);
      tests++;
      if (cap[0] !== 32'h7f7f7f7f || cap[3] !== 32'h7f7f7f7f) begin
         fails++;
         $display("FAIL two_tile_sat: row0=%h row3=%h, required 7f7f7f7f", cap[0], cap[3]);
      end
   endtask

   task automatic test_negatives();
      fill_const(-40);
      run_tile(1, 1, 1, 0, 0);
      drain(0, -1, ROWS);
      tests++;
      if (cap[2] !== 32'hecececec) begin
         fails++;
         $display("FAIL neg_shift: row2=%h, required ecececec", cap[2]);
      end
      run_tile(1, 1, 1, 1, 1);
      drain(0, -1, ROWS);
      tests++;
      if (cap[1] !== 32'h00000000) begin
         fails++;
         $display("FAIL neg_relu: row1=%h, required 00000000", cap[1]);
      end
      fill_const(-1000);
      run_tile(1, 1, 1, 0, 0);
      drain(0, -1, ROWS);
      tests++;
      if (cap[3] !== 32'h80808080) begin
         fails++;
         $display("FAIL neg_sat: row3=%h, required 80808080", cap[3]);
      end
   endtask

   task automatic test_backpressure();
      fill_rand(-2000, 2000);
      run_tile(1, 1, 3, 0, 1);
      drain(1, -1, ROWS);
   endtask

   task automatic test_errors();
      fill_rand(-500, 500);
      inject = 1;
      run_tile(1, 1, 1, 0, 0);
      inject = 0;
      tests++;
      if (err !== 1'b1) begin
         fails++;
         $display("FAIL fifth_valid_err: err=%b, required 1", err);
      end
      drain(0, 2, ROWS);
      tests++;
      if (err !== 1'b1) begin
         fails++;
         $display("FAIL err_sticky: err=%b, required 1", err);
      end
      fill_rand(-500, 500);
      run_tile(1, 1, 0, 1, 1);
      drain(2, -1, ROWS);
   endtask

   task automatic test_reset_mid_drain();
      fill_rand(-3000, 3000);
      run_tile(1, 1, 2, 0, 1);
      drain(0, -1, 2);
      @(negedge clk);
      o_ready = 0;
      rst = 0;
      #1;
      tests++;
      if (o_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_drain: o_valid=%b busy=%b, required 0 0", o_valid, busy);
      end
      @(negedge clk);
      rst = 1;
      fill_rand(-3000, 3000);
      run_tile(1, 1, 2, 0, 1);
      drain(0, -1, ROWS);
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         fill_rand(-3000, 3000);
         run_tile(1, 0, 0, 0, 1);
         fill_rand(-3000, 3000);
         run_tile(0, 0, 0, 0, 1);
         fill_rand(-3000, 3000);
         run_tile(0, 1, int'($urandom_range(0, 6)), $urandom_range(0, 1) == 1, 1);
         drain(2, -1, ROWS);
      end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_two_tiles();
      test_negatives();
      test_backpressure();
      test_errors();
      test_reset_mid_drain();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
